rx_width_serializer: RTL and testbench

RX_WIDTH_SERIALIZER -- requirements
Module: rx_width_serializer

---
 rtl/rx_width_serializer_pkg.sv | 15 +
 rtl/rx_width_serializer_if.sv | 47 ++++
 rtl/rx_width_serializer_beat_counter.sv | 31 +++
 rtl/rx_width_serializer.sv | 105 ++++++++++
 tb/tb_rx_width_serializer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/rx_width_serializer_pkg.sv
// Shared types and helpers for the RX width serializer.
// Optional feature macro: RX_SER_LAST_EN (adds data_rx_last_o).
package rx_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A beat count of zero or anything above RATIO means "whole word".
    function automatic int eff_beats(input int nbeats, input int ratio);
        return (nbeats == 0 || nbeats > ratio) ? ratio : nbeats;
    endfunction

endpackage

// File: rtl/rx_width_serializer_if.sv
// Wide-word in / narrow-beat out handshake bundle for rx_width_serializer.
// data_rx_last_o exists only when RX_SER_LAST_EN is defined.
interface rx_ser_if #(
    parameter int OUT_W = 32,
    parameter int RATIO = 2,
    parameter int CW    = $clog2(RATIO) + 1
);
    localparam int IN_W = OUT_W * RATIO;

    logic [IN_W-1:0]  data_rx_rdata_i;
    logic [CW-1:0]    data_rx_nbeats_i;
    logic             data_rx_valid_i;
    logic             data_rx_ready_o;
    logic [OUT_W-1:0] data_rx_rdata_o;
    logic             data_rx_valid_o;
    logic             data_rx_ready_i;
`ifdef RX_SER_LAST_EN
    logic             data_rx_last_o;
`endif

    modport master (
`ifdef RX_SER_LAST_EN
        input  data_rx_last_o,
`endif
        output data_rx_rdata_i,
        output data_rx_nbeats_i,
        output data_rx_valid_i,
        output data_rx_ready_i,
        input  data_rx_ready_o,
        input  data_rx_rdata_o,
        input  data_rx_valid_o
    );

    modport slave (
`ifdef RX_SER_LAST_EN
        output data_rx_last_o,
`endif
        input  data_rx_rdata_i,
        input  data_rx_nbeats_i,
        input  data_rx_valid_i,
        input  data_rx_ready_i,
        output data_rx_ready_o,
        output data_rx_rdata_o,
        output data_rx_valid_o
    );

endinterface

// File: rtl/rx_width_serializer_beat_counter.sv
// Beat index and final-beat detection for the width serializer.
// Holds the effective beat count of the word in flight.
module rx_ser_beat_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          advance,
    input  logic [CW-1:0] count,
    output logic [CW-1:0] index,
    output logic          last_beat
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            index   <= '0;
            count_q <= '0;
        end else if (load) begin
            index   <= '0;
            count_q <= count;
        end else if (advance && !last_beat) begin
            index <= index + CW'(1);
        end
    end

    assign last_beat = (index == count_q - CW'(1));

endmodule

// File: rtl/rx_width_serializer.sv
// Splits each wide RX word into OUT_W beats toward L2, no bubble between words.
// Define RX_SER_LAST_EN to add the data_rx_last_o end-of-word marker.
module rx_width_serializer
    import rx_ser_pkg::*;
#(
    parameter int OUT_W = 32,
    parameter int RATIO = 2,
    parameter int CW    = $clog2(RATIO) + 1
) (
    input  logic     sys_clk,
    input  logic     rst,
    input  logic     cfg_msb_first_i,
    rx_ser_if.slave  bus
);

    localparam int IN_W = OUT_W * RATIO;

    state_t          state;
    state_t          state_nx;
    logic [IN_W-1:0] word_q;
    logic            msb_q;
    logic [CW-1:0]   eff;
    logic [CW-1:0]   index;
    logic [CW-1:0]   sel;
    logic            last_beat;
    logic            ready;
    logic            valid;
    logic            accept;
    logic            advance;
`ifdef RX_SER_LAST_EN
    logic            last;
`endif

    assign eff     = CW'(eff_beats(int'(bus.data_rx_nbeats_i), RATIO));
    assign accept  = ready & bus.data_rx_valid_i;
    assign advance = (state == SHIFT) & bus.data_rx_ready_i;

    rx_ser_beat_counter #(.CW(CW)) u_cnt (
        .clk       (sys_clk),
        .rst       (rst),
        .load      (accept),
        .advance   (advance),
        .count     (eff),
        .index     (index),
        .last_beat (last_beat)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (bus.data_rx_valid_i) state_nx = SHIFT;
            SHIFT: if (last_beat && bus.data_rx_ready_i
                       && !bus.data_rx_valid_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ready on the final beat tracks ready_i only, never valid_i
    always_comb begin
        ready = 1'b0;
        valid = 1'b0;
`ifdef RX_SER_LAST_EN
        last  = 1'b0;
`endif
        if (!rst) begin
            unique case (state)
                IDLE:  ready = 1'b1;
                SHIFT: begin
                    valid = 1'b1;
                    ready = last_beat & bus.data_rx_ready_i;
`ifdef RX_SER_LAST_EN
                    last  = last_beat;
`endif
                end
                default: ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            word_q <= '0;
            msb_q  <= 1'b0;
        end else if (accept) begin
            word_q <= bus.data_rx_rdata_i;
            msb_q  <= cfg_msb_first_i;
        end
    end

    assign sel = msb_q ? (CW'(RATIO - 1) - index) : index;

    assign bus.data_rx_ready_o = ready;
    assign bus.data_rx_valid_o = valid;
    assign bus.data_rx_rdata_o = valid ? word_q[int'(sel)*OUT_W +: OUT_W]
                                       : '0;
`ifdef RX_SER_LAST_EN
    assign bus.data_rx_last_o  = last;
`endif

endmodule

// File: tb/tb_rx_width_serializer.sv
// Directed vector bench for rx_width_serializer (RATIO=2 and RATIO=4 builds).
// Also checks data_rx_last_o when RX_SER_LAST_EN is defined.
module tb_rx_width_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic msb2 = 1'b0;
    logic msb4 = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rx_ser_if #(.OUT_W(32), .RATIO(2)) b2 ();
    rx_ser_if #(.OUT_W(32), .RATIO(4)) b4 ();

    rx_width_serializer #(.OUT_W(32), .RATIO(2)) u2 (
        .sys_clk         (clk),
        .rst             (rst),
        .cfg_msb_first_i (msb2),
        .bus             (b2)
    );

    rx_width_serializer #(.OUT_W(32), .RATIO(4)) u4 (
        .sys_clk         (clk),
        .rst             (rst),
        .cfg_msb_first_i (msb4),
        .bus             (b4)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [63:0] data;
        logic [1:0]  nb;
        logic        msb;
        logic        ready;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_dat;
    } vec_t;

    localparam logic [63:0] W = 64'h11112222_33334444;
    localparam logic [63:0] V = 64'hAAAABBBB_CCCCDDDD;
    localparam logic [63:0] X = 64'h01234567_89ABCDEF;

    task automatic chk(input string nm,
                       input logic ar, input logic av, input logic [31:0] ad,
                       input logic er, input logic ev, input logic [31:0] ed);
        n_vec++;
        if (ar !== er || av !== ev || ad !== ed) begin
            n_err++;
            $display("FAIL %s: ready=%0b valid=%0b data=%h, want ready=%0b valid=%0b data=%h",
                     nm, ar, av, ad, er, ev, ed);
        end
    endtask

    task automatic chk_bit(input string nm, input logic a, input logic e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0b, want %0b", nm, a, e);
        end
    endtask

    task automatic drive4(input logic v, input logic [127:0] d,
                          input logic [2:0] nb, input logic m, input logic r);
        b4.data_rx_valid_i  = v;
        b4.data_rx_rdata_i  = d;
        b4.data_rx_nbeats_i = nb;
        msb4                = m;
        b4.data_rx_ready_i  = r;
    endtask

    task automatic step4(input string nm, input logic er, input logic ev,
                         input logic [31:0] ed);
        @(negedge clk);
        chk(nm, b4.data_rx_ready_o, b4.data_rx_valid_o, b4.data_rx_rdata_o,
            er, ev, ed);
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input string nm, input logic r, input logic v,
                         input logic [63:0] d, input logic ri,
                         input logic er, input logic ev, input logic [31:0] ed);
        rst                 = r;
        b2.data_rx_valid_i  = v;
        b2.data_rx_rdata_i  = d;
        b2.data_rx_nbeats_i = 2'd2;
        msb2                = 1'b0;
        b2.data_rx_ready_i  = ri;
        @(negedge clk);
        chk(nm, b2.data_rx_ready_o, b2.data_rx_valid_o, b2.data_rx_rdata_o,
            er, ev, ed);
        @(posedge clk);
        #1;
    endtask

    vec_t tv[$];
    logic [127:0] wa;
    logic [127:0] wb;
    logic [127:0] wc;

    initial begin
        tv.push_back('{1, 0, 64'h0, 2'd0, 0, 1, 0, 0, 32'h0});
        tv.push_back('{0, 1, W,     2'd2, 0, 1, 1, 0, 32'h0});
        tv.push_back('{0, 0, 64'h0, 2'd0, 0, 1, 0, 1, 32'h33334444});
        tv.push_back('{0, 0, 64'h0, 2'd0, 0, 1, 1, 1, 32'h11112222});
        tv.push_back('{0, 1, W,     2'd0, 1, 1, 1, 0, 32'h0});
        tv.push_back('{0, 0, 64'h0, 2'd0, 0, 1, 0, 1, 32'h11112222});
        tv.push_back('{0, 0, 64'h0, 2'd0, 1, 1, 1, 1, 32'h33334444});
        tv.push_back('{0, 1, V,     2'd2, 0, 1, 1, 0, 32'h0});
        tv.push_back('{0, 1, X,     2'd2, 0, 1, 0, 1, 32'hCCCCDDDD});
        tv.push_back('{0, 1, X,     2'd2, 0, 1, 1, 1, 32'hAAAABBBB});
        tv.push_back('{0, 0, 64'h0, 2'd2, 0, 1, 0, 1, 32'h89ABCDEF});
        tv.push_back('{0, 0, 64'h0, 2'd2, 0, 0, 0, 1, 32'h01234567});
        tv.push_back('{0, 0, 64'h0, 2'd2, 0, 1, 1, 1, 32'h01234567});
        tv.push_back('{0, 0, 64'h0, 2'd2, 0, 1, 1, 0, 32'h0});
        tv.push_back('{0, 1, V,     2'd1, 1, 1, 1, 0, 32'h0});
        tv.push_back('{0, 0, 64'h0, 2'd0, 0, 1, 1, 1, 32'hAAAABBBB});
        tv.push_back('{0, 1, X,     2'd3, 0, 1, 1, 0, 32'h0});
        tv.push_back('{0, 0, 64'h0, 2'd0, 0, 1, 0, 1, 32'h89ABCDEF});
        tv.push_back('{0, 0, 64'h0, 2'd0, 0, 1, 1, 1, 32'h01234567});
        tv.push_back('{0, 0, 64'h0, 2'd0, 0, 1, 1, 0, 32'h0});

        b2.data_rx_valid_i  = 1'b0;
        b2.data_rx_rdata_i  = '0;
        b2.data_rx_nbeats_i = '0;
        b2.data_rx_ready_i  = 1'b0;
        drive4(1'b0, 128'h0, 3'd0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tv.size(); i++) begin
            rst                 = tv[i].rst;
            b2.data_rx_valid_i  = tv[i].valid;
            b2.data_rx_rdata_i  = tv[i].data;
            b2.data_rx_nbeats_i = tv[i].nb;
            msb2                = tv[i].msb;
            b2.data_rx_ready_i  = tv[i].ready;
            @(negedge clk);
            chk($sformatf("vec%0d", i), b2.data_rx_ready_o,
                b2.data_rx_valid_o, b2.data_rx_rdata_o,
                tv[i].e_rdy, tv[i].e_vld, tv[i].e_dat);
            @(posedge clk);
            #1;
        end
        b2.data_rx_valid_i = 1'b0;

        // Back-to-back: A with 3 beats, then B with nbeats=0 (all 4)
        wa = 128'hA0000003_A0000002_A0000001_A0000000;
        wb = 128'hB0000003_B0000002_B0000001_B0000000;
        drive4(1'b1, wa, 3'd3, 1'b0, 1'b1);
        step4("b2b_idle", 1'b1, 1'b0, 32'h0);
        drive4(1'b1, wb, 3'd0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++)
            step4($sformatf("b2b_a%0d", k), k == 2, 1'b1, 32'hA0000000 + k);
        drive4(1'b0, 128'h0, 3'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++)
            step4($sformatf("b2b_b%0d", k), k == 3, 1'b1, 32'hB0000000 + k);
        step4("b2b_end", 1'b1, 1'b0, 32'h0);

        // Stall five cycles on beat 1
        wc = 128'hC0000003_C0000002_C0000001_C0000000;
        drive4(1'b1, wc, 3'd4, 1'b0, 1'b1);
        step4("stall_acc", 1'b1, 1'b0, 32'h0);
        drive4(1'b0, 128'h0, 3'd0, 1'b1, 1'b1);
        step4("stall_b0", 1'b0, 1'b1, 32'hC0000000);
        b4.data_rx_ready_i = 1'b0;
        for (int k = 0; k < 5; k++)
            step4($sformatf("stall_hold%0d", k), 1'b0, 1'b1, 32'hC0000001);
        b4.data_rx_ready_i = 1'b1;
        step4("stall_b1", 1'b0, 1'b1, 32'hC0000001);
        step4("stall_b2", 1'b0, 1'b1, 32'hC0000002);
        step4("stall_b3", 1'b1, 1'b1, 32'hC0000003);
        step4("stall_end", 1'b1, 1'b0, 32'h0);

`ifdef RX_SER_LAST_EN
        drive4(1'b1, wc, 3'd2, 1'b0, 1'b1);
        @(negedge clk);
        chk_bit("last_idle", b4.data_rx_last_o, 1'b0);
        @(posedge clk);
        #1;
        drive4(1'b0, 128'h0, 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk_bit("last_b0", b4.data_rx_last_o, 1'b0);
        chk("last_b0_dat", b4.data_rx_ready_o, b4.data_rx_valid_o,
            b4.data_rx_rdata_o, 1'b0, 1'b1, 32'hC0000000);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_bit("last_b1", b4.data_rx_last_o, 1'b1);
        chk("last_b1_dat", b4.data_rx_ready_o, b4.data_rx_valid_o,
            b4.data_rx_rdata_o, 1'b1, 1'b1, 32'hC0000001);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_bit("last_after", b4.data_rx_last_o, 1'b0);
        @(posedge clk);
        #1;
`endif

        // Reset mid-word discards the second beat
        step2("rst_acc", 1'b0, 1'b1, W, 1'b1, 1'b1, 1'b0, 32'h0);
        step2("rst_b0", 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 32'h33334444);
        step2("rst_hi", 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        step2("rst_idle", 1'b0, 1'b1, X, 1'b1, 1'b1, 1'b0, 32'h0);
        step2("rst_nb0", 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 32'h89ABCDEF);
        step2("rst_nb1", 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 32'h01234567);
        step2("rst_end", 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
